// File: rtl/qsys_system_switches_debounced.sv
// rtl/qsys_system_switches_debounced.sv - Avalon-MM input PIO with sync, debounce, edge capture and IRQ
module qsys_system_switches_debounced #(
  parameter int WIDTH            = 10,
  parameter int DEBOUNCE_W       = 16,
  parameter int DEFAULT_DEBOUNCE = 50000,
  parameter int EDGE_TYPE        = 0,
  parameter int IRQ_MODE         = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  localparam logic [DEBOUNCE_W:0]   ONE_EXT    = (DEBOUNCE_W+1)'(1);
  localparam logic [DEBOUNCE_W-1:0] THRESH_RST = DEBOUNCE_W'(DEFAULT_DEBOUNCE);

  logic [WIDTH-1:0]      sync1_q, sync2_q;
  logic [WIDTH-1:0]      stable_q, stable_d;
  logic [WIDTH-1:0]      capture_q, capture_d;
  logic [WIDTH-1:0]      mask_q;
  logic [DEBOUNCE_W-1:0] thresh_q;
  logic [DEBOUNCE_W-1:0] cnt_q [WIDTH];
  logic [DEBOUNCE_W-1:0] cnt_d [WIDTH];
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;

  logic                  wr_en;
  logic [DEBOUNCE_W:0]   neff;
  logic [DEBOUNCE_W:0]   cnt_inc;
  logic [WIDTH-1:0]      commit;
  logic [WIDTH-1:0]      edge_hit;
  logic [WIDTH-1:0]      clr_bits;
  logic                  unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Effective threshold: a programmed 0 acts as 1 so a bit always needs one mismatching cycle
  always_comb begin
    neff = {1'b0, thresh_q};
    if (thresh_q == '0) neff = ONE_EXT;
  end

  // Per-bit filter: count consecutive mismatches, commit once the run reaches the threshold
  always_comb begin
    commit  = '0;
    cnt_inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      cnt_inc  = {1'b0, cnt_q[i]} + ONE_EXT;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_inc >= neff) commit[i] = 1'b1;
        else                 cnt_d[i]  = cnt_inc[DEBOUNCE_W-1:0];
      end
    end
    stable_d = stable_q ^ commit;
  end

  // Edge qualification and W1C capture; a same-cycle edge overrides the clear
  always_comb begin
    case (EDGE_TYPE)
      1:       edge_hit = commit & sync2_q;
      2:       edge_hit = commit & ~sync2_q;
      default: edge_hit = commit;
    endcase
    clr_bits = '0;
    if (wr_en && address == 3'd3) clr_bits = writedata[WIDTH-1:0];
    capture_d = (capture_q & ~clr_bits) | edge_hit;
  end

  // Read mux and interrupt source, both registered one cycle later
  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0:    readdata_d[WIDTH-1:0]      = stable_q;
      3'd1:    readdata_d[WIDTH-1:0]      = sync2_q;
      3'd2:    readdata_d[WIDTH-1:0]      = mask_q;
      3'd3:    readdata_d[WIDTH-1:0]      = capture_q;
      3'd4:    readdata_d[DEBOUNCE_W-1:0] = thresh_q;
      default: readdata_d = '0;
    endcase
    if (IRQ_MODE == 1) irq_d = |(capture_q & mask_q);
    else               irq_d = |(stable_q & mask_q);
  end

  // State update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      capture_q  <= '0;
      mask_q     <= '0;
      thresh_q   <= THRESH_RST;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      capture_q  <= capture_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      if (wr_en && address == 3'd2) mask_q   <= writedata[WIDTH-1:0];
      if (wr_en && address == 3'd4) thresh_q <= writedata[DEBOUNCE_W-1:0];
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_qsys_system_switches_debounced.sv
// tb/tb_qsys_system_switches_debounced.sv - self-checking bench for qsys_system_switches_debounced
module tb_qsys_system_switches_debounced;
  localparam int W = 10;

  logic          clk = 1'b0;
  logic          reset, chipselect, write_n;
  logic [2:0]    address;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_a, rd_f;
  logic          irq_a, irq_f;

  int vectors = 0;
  int miscompares = 0;

  // Reference state (two builds: any-edge/edge-irq and falling-only/level-irq)
  bit [W-1:0] m_s1, m_s2, m_stable, m_cap_a, m_cap_f, m_mask;
  int         run_len [W];
  int         m_thr;
  bit [31:0]  m_rd_a, m_rd_f;
  bit         m_irq_a, m_irq_f;

  always #5 clk = ~clk;

  qsys_system_switches_debounced #(.WIDTH(W), .DEBOUNCE_W(16), .DEFAULT_DEBOUNCE(50000),
                                   .EDGE_TYPE(0), .IRQ_MODE(1)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .irq(irq_a),
    .in_port(in_port));

  qsys_system_switches_debounced #(.WIDTH(W), .DEBOUNCE_W(16), .DEFAULT_DEBOUNCE(50000),
                                   .EDGE_TYPE(2), .IRQ_MODE(0)) dut_f (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_f), .irq(irq_f),
    .in_port(in_port));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] reg_view(input int a, input bit [W-1:0] cap);
    case (a)
      0: return 32'(m_stable);
      1: return 32'(m_s2);
      2: return 32'(m_mask);
      3: return 32'(cap);
      4: return 32'(m_thr);
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the register map as described: every new value from the old state
  task automatic model_step();
    bit [W-1:0] commits, clr;
    int neff;
    bit wr;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_cap_a = '0; m_cap_f = '0; m_mask = '0;
      m_thr = 50000; m_rd_a = 0; m_rd_f = 0; m_irq_a = 0; m_irq_f = 0;
      for (int i = 0; i < W; i++) run_len[i] = 0;
      return;
    end
    m_rd_a  = reg_view(int'(address), m_cap_a);
    m_rd_f  = reg_view(int'(address), m_cap_f);
    m_irq_a = (m_cap_a & m_mask) != 0;
    m_irq_f = (m_stable & m_mask) != 0;
    neff = (m_thr == 0) ? 1 : m_thr;
    commits = '0;
    for (int i = 0; i < W; i++) begin
      if (m_s2[i] == m_stable[i]) run_len[i] = 0;
      else if (run_len[i] + 1 >= neff) begin
        commits[i] = 1'b1;
        run_len[i] = 0;
      end else run_len[i]++;
    end
    wr  = chipselect && !write_n;
    clr = (wr && address == 3) ? writedata[W-1:0] : '0;
    m_cap_a  = (m_cap_a & ~clr) | commits;
    m_cap_f  = (m_cap_f & ~clr) | (commits & m_stable);
    m_stable = m_stable ^ commits;
    if (wr && address == 2) m_mask = writedata[W-1:0];
    if (wr && address == 4) m_thr  = int'(writedata[15:0]);
    m_s2 = m_s1;
    m_s1 = in_port;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("rd_any", rd_a, m_rd_a);
    chk("rd_fall", rd_f, m_rd_f);
    chk("irq_edge", {31'd0, irq_a}, {31'd0, m_irq_a});
    chk("irq_level", {31'd0, irq_f}, {31'd0, m_irq_f});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
    writedata = '0; in_port = '0;
    m_thr = 50000;
    ticks(2);
    reset = 1'b0;
    chk("reset_rd", rd_a, 32'd0);
    chk("reset_irq", {31'd0, irq_a}, 32'd0);
    for (int a = 0; a < 5; a++) begin
      address = 3'(a);
      tick();
      chk("reset_reg", rd_a, (a == 4) ? 32'd50000 : 32'd0);
    end

    // Clean debounce with N=4
    bus_write(3'd4, 32'd4);
    address = 3'd0;
    in_port[0] = 1'b1;
    tick();
    ticks(5);
    chk("clean_data_early", {31'd0, rd_a[0]}, 32'd0);
    tick();
    chk("clean_data_set", {31'd0, rd_a[0]}, 32'd1);
    address = 3'd3;
    tick();
    chk("clean_cap_any", {31'd0, rd_a[0]}, 32'd1);
    chk("clean_cap_fall", {31'd0, rd_f[0]}, 32'd0);
    chk("clean_irq_masked", {31'd0, irq_a}, 32'd0);
    bus_write(3'd2, 32'd1);
    chk("mask_irq_same", {31'd0, irq_a}, 32'd0);
    tick();
    chk("mask_irq_next", {31'd0, irq_a}, 32'd1);
    bus_write(3'd3, 32'd1);
    tick();
    chk("w1c_cap", {31'd0, rd_a[0]}, 32'd0);
    chk("w1c_irq", {31'd0, irq_a}, 32'd0);

    // Glitch rejection then a pulse just long enough
    address = 3'd0;
    in_port[3] = 1'b1; ticks(3);
    in_port[3] = 1'b0; ticks(8);
    chk("glitch_data", {31'd0, rd_a[3]}, 32'd0);
    address = 3'd3; tick();
    chk("glitch_cap", {31'd0, rd_a[3]}, 32'd0);
    in_port[3] = 1'b1; ticks(4);
    in_port[3] = 1'b0; ticks(12);
    chk("pulse_cap_any", {31'd0, rd_a[3]}, 32'd1);
    chk("pulse_cap_fall", {31'd0, rd_f[3]}, 32'd1);
    bus_write(3'd3, 32'h3FF);

    // Edge type with N=1
    bus_write(3'd4, 32'd1);
    address = 3'd3;
    in_port[5] = 1'b1; ticks(5);
    chk("rise_any", {31'd0, rd_a[5]}, 32'd1);
    chk("rise_fall_only", {31'd0, rd_f[5]}, 32'd0);
    in_port[5] = 1'b0; ticks(5);
    chk("fall_fall_only", {31'd0, rd_f[5]}, 32'd1);

    // Set-vs-clear race on bit 2
    bus_write(3'd2, 32'h3FF);
    bus_write(3'd3, 32'h3FF);
    in_port[2] = 1'b1;
    tick();
    tick();
    bus_write(3'd3, 32'h4);
    address = 3'd3;
    tick();
    chk("race_cap", {31'd0, rd_a[2]}, 32'd1);
    chk("race_irq", {31'd0, irq_a}, 32'd1);
    tick();
    chk("race_irq_hold", {31'd0, irq_a}, 32'd1);

    // Threshold lowered mid-count
    bus_write(3'd4, 32'd100);
    address = 3'd0;
    in_port[1] = 1'b1;
    tick();
    ticks(7);
    chk("thr_before", {31'd0, rd_a[1]}, 32'd0);
    bus_write(3'd4, 32'd5);
    address = 3'd0;
    tick();
    chk("thr_commit_edge", {31'd0, rd_a[1]}, 32'd0);
    tick();
    chk("thr_commit_read", {31'd0, rd_a[1]}, 32'd1);

    // N=0 behaves as N=1
    bus_write(3'd4, 32'd0);
    address = 3'd0;
    in_port[7] = 1'b1;
    ticks(3);
    chk("n0_early", {31'd0, rd_a[7]}, 32'd0);
    tick();
    chk("n0_set", {31'd0, rd_a[7]}, 32'd1);
    chk("level_irq", {31'd0, irq_f}, 32'd1);

    // Reset in the middle of a count
    bus_write(3'd4, 32'd10);
    in_port[8] = 1'b1;
    ticks(5);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("midreset_rd", rd_a, 32'd0);
    bus_write(3'd4, 32'd3);
    ticks(8);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) in_port[$urandom_range(W-1)] ^= 1'b1;
      if ($urandom_range(7) == 0) begin
        logic [2:0]  wa;
        logic [31:0] wd;
        wa = 3'($urandom_range(7));
        wd = $urandom();
        if (wa == 3'd4) wd = 32'($urandom_range(6));
        bus_write(wa, wd);
      end else begin
        address = 3'($urandom_range(7));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/qsys_system_switches_debounced.md
# qsys_system_switches_debounced

Parametrised Avalon-MM input PIO for board switches and push-buttons that replaces the plain input port with per-bit synchronisation, a run-time programmable debounce filter, and a selectable edge type. Edge capture and IRQ generation run on the filtered value. Sits on the Nios II data master interconnect beside the other PIO slaves and drives one IRQ line.

## Interface
- WIDTH, 10: number of input bits, 1..32.
- DEBOUNCE_W, 16: debounce counter and threshold register width, 1..32.
- DEFAULT_DEBOUNCE, 50000: reset value of the threshold register (1 ms at 50 MHz). Must fit in DEBOUNCE_W bits.
- EDGE_TYPE, 0: capture on 0 = any edge, 1 = rising, 2 = falling.
- IRQ_MODE, 1: 0 = level (irq from stable & mask), 1 = edge (irq from edge_capture & mask).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  registered read data; reset 0.
- irq  out  1  registered interrupt request; reset 0.
- in_port  in  WIDTH  asynchronous switch inputs.

## Operation
Register map (unused bits read 0, writes to RO/unmapped addresses are ignored):
- 0 DATA, RO: debounced stable[WIDTH-1:0].
- 1 RAW, RO: synchronised sync2[WIDTH-1:0].
- 2 IRQ_MASK, RW: mask[WIDTH-1:0]; reset 0.
- 3 EDGE_CAPTURE, W1C: capture[WIDTH-1:0]. Writing 1 clears the bit; writing 0 leaves it unchanged.
- 4 DEBOUNCE, RW: threshold N[DEBOUNCE_W-1:0]; reset DEFAULT_DEBOUNCE.
- 5-7: read 0.

Datapath, per bit i:
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
- Filter: counter cnt[i] of DEBOUNCE_W bits.
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Otherwise, with Neff = max(N,1): if cnt[i]+1 >= Neff (compared at DEBOUNCE_W+1 bits, no overflow), then stable[i] <= sync2[i] and cnt[i] <= 0. Else cnt[i] <= cnt[i]+1.
  - A bit commits only after the mismatch has lasted Neff consecutive cycles. Any glitch back to stable restarts the count.
- Commit event: qualifies as an edge if it matches EDGE_TYPE (rising: 0->1, falling: 1->0, any: both). A qualifying edge sets capture[i] on the same clock edge that stable[i] changes.
- Simultaneous W1C clear and a qualifying edge on the same bit: the set wins, so the edge is not lost.
- Writing DEBOUNCE mid-count takes effect on the next cycle. If cnt[i]+1 >= new Neff, a still-mismatching bit commits on that next cycle.
- irq <= |(capture & mask) in edge mode, or |(stable & mask) in level mode. irq is registered, one cycle after its sources.
- readdata <= mux(address) every cycle, independent of chipselect (read latency 1).

Reset (synchronous, all at once):
- sync1, sync2, stable, cnt, capture, mask, readdata and irq go to 0.
- DEBOUNCE goes to DEFAULT_DEBOUNCE.
- Inputs held high through reset therefore commit as rising edges Neff cycles after sync2 settles.
- Reset asserted mid-count discards the partial count.

## Timing
- in_port changes before edge k: sync2 changes at k+1, stable at k+1+Neff, capture at k+1+Neff, irq at k+2+Neff.
- Read: address is presented at edge r and readdata is valid after edge r+1. A value committed at edge r appears in readdata at r+1.
- Write: the register updates at the edge where chipselect && !write_n is sampled. A W1C clear drops irq one edge later, unless the same edge re-sets the bit.
- All state is in the clk domain. in_port is the only asynchronous input.

## Test plan
- Reset defaults: assert reset 2 cycles, then read addresses 0-4 -> 0, 0, 0, 0, 50000; irq = 0.
- Clean debounce: N=4, drive in_port[0] 0->1 at edge k -> DATA bit0 = 1 from k+5, capture bit0 set at k+5, irq 0 while mask = 0. Write mask = 1 -> irq 1 one edge after the mask write. Write 1 to address 3 -> capture 0, irq 0.
- Glitch reject: N=4, pulse in_port[3] high for 3 cycles, then low -> stable and capture bit3 never change, and the counter restarts. A 4-cycle pulse -> bit3 commits.
- Edge type: EDGE_TYPE=2, N=1, toggle bit 5 0->1->0 -> capture set only on the falling commit. Any-edge build -> set on both.
- Set-vs-clear race: write 1 to EDGE_CAPTURE bit 2 on the same edge bit 2 commits a qualifying edge -> capture bit2 stays 1 and irq stays 1.
- Threshold change and N=0: with bit 1 mismatching and cnt=6 under N=100, write N=5 -> commits on the next cycle. N=0 behaves as N=1: commit 1 cycle after sync2 changes. In level mode with mask = 0x3FF, irq tracks |stable.
